// File: rtl/prbs_checker_pkg.sv
// Shared types and PRBS helpers for the RX PRBS checker.
// prbs_next/prbs_pred use the same LFSR form as the TX generator:
// feedback = s[ORDER-1] ^ s[TAP-1], shift left, feedback enters the LSB.
package prbs_checker_pkg;

    localparam int FILTER_OUT_WIDTH = 16;
    typedef logic signed [FILTER_OUT_WIDTH-1:0] filter_out_t;

    typedef logic [31:0] cnt_t;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Predicted next bit for an LFSR state held in the low 'order' bits of s.
    function automatic logic prbs_pred(input logic [31:0] s, input int unsigned order,
                                       input int unsigned tap);
        logic [31:0] t;
        t = (s >> (order - 1)) ^ (s >> (tap - 1));
        return t[0];
    endfunction

    // One free-running LFSR step; result is masked to 'order' bits.
    function automatic logic [31:0] prbs_next(input logic [31:0] s, input int unsigned order,
                                              input int unsigned tap);
        logic [31:0] mask;
        mask = (32'd1 << order) - 32'd1;
        return ((s << 1) | {31'd0, prbs_pred(s, order, tap)}) & mask;
    endfunction

endpackage

// File: rtl/prbs_checker_rx_slicer.sv
// Sign slicer: bit = (sig >= 0) ^ polarity, captured on each sample strobe.
module prbs_checker_rx_slicer
    import prbs_checker_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cke,
    input  filter_out_t i_sig,
    input  logic        i_polarity,
    output logic        o_bit
);

    logic r_bit;
    logic w_nonneg;

    assign w_nonneg = (i_sig >= filter_out_t'(0));
    assign o_bit    = r_bit;

    // Capture the sliced bit on the strobe; hold otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst)      r_bit <= 1'b0;
        else if (i_cke) r_bit <= w_nonneg ^ i_polarity;
    end

endmodule

// File: rtl/prbs_checker.sv
// RX PRBS checker: slices sig_rx, self-synchronises a local LFSR (SEED ->
// VERIFY -> LOCKED) and counts bit errors while locked. In LOCKED the LFSR
// free-runs so received errors never corrupt the reference.
// Optional feature macro: PRBS_CHK_POLARITY_EN (detect and correct an
// inverted stream); without it polarity is tied to 0.
module prbs_checker
    import prbs_checker_pkg::*;
#(
    parameter int PRBS_ORDER  = 7,
    parameter int PRBS_TAP    = 6,
    parameter int LOCK_THRESH = 64,
    parameter int WINDOW      = 256,
    parameter int UNLOCK_ERRS = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 i_clk_sys,
    input  logic                 i_rst,
    input  logic                 i_cke_rx,
    input  filter_out_t          i_sig_rx,
    input  logic                 i_clr_cnt,
    output logic                 o_rx_bit,
    output logic                 o_locked,
    output logic                 o_err_pulse,
    output logic [CNT_WIDTH-1:0] o_bit_count,
    output logic [CNT_WIDTH-1:0] o_err_count,
    output logic                 o_polarity
);

    localparam int SW = $clog2(PRBS_ORDER + 1);
    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int WW = $clog2(WINDOW);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);

    state_e                r_state, w_state_nxt;
    logic                  r_adv;
    logic [PRBS_ORDER-1:0] r_lfsr;
    logic [SW-1:0]         r_shift_cnt;
    logic [MW-1:0]         r_match_cnt;
    logic [WW-1:0]         r_win_cnt;
    logic [EW-1:0]         r_win_err;
    logic [CNT_WIDTH-1:0]  r_bit_count, r_err_count;
    logic                  r_err_pulse;

    logic                  w_pol, w_pred, w_match, w_seed_done, w_win_last;
    logic                  w_lock, w_unlock, w_cnt_bit, w_cnt_err;
    logic [31:0]           w_lfsr32;
    logic [PRBS_ORDER-1:0] w_seed_lfsr, w_fly_lfsr;

    prbs_checker_rx_slicer u_slicer (
        .i_clk      (i_clk_sys),
        .i_rst      (i_rst),
        .i_cke      (i_cke_rx),
        .i_sig      (i_sig_rx),
        .i_polarity (w_pol),
        .o_bit      (o_rx_bit)
    );

    assign w_lfsr32    = 32'(r_lfsr);
    assign w_pred      = prbs_pred(w_lfsr32, PRBS_ORDER, PRBS_TAP);
    assign w_match     = (o_rx_bit == w_pred);
    assign w_seed_lfsr = {r_lfsr[PRBS_ORDER-2:0], o_rx_bit};
    assign w_fly_lfsr  = PRBS_ORDER'(prbs_next(w_lfsr32, PRBS_ORDER, PRBS_TAP));
    assign w_seed_done = (r_shift_cnt == SW'(PRBS_ORDER - 1));
    assign w_win_last  = (r_win_cnt == WW'(WINDOW - 1));
    assign w_lock      = w_match && (r_match_cnt == MW'(LOCK_THRESH - 1));
    assign w_unlock    = !w_match && (r_win_err == EW'(UNLOCK_ERRS - 1));

`ifdef PRBS_CHK_POLARITY_EN
    logic [MW-1:0] r_mis_cnt;
    logic          r_pol;
    logic          w_inv_done, w_pol_flip;

    // A run of mispredictions with no prior match means a complemented stream.
    assign w_inv_done = !w_match && (r_match_cnt == '0) &&
                        (r_mis_cnt == MW'(LOCK_THRESH - 1));
    assign w_pol      = r_pol;
`else
    assign w_pol      = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) r_state <= ST_SEED;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode; only a consumed bit (one cycle after the strobe) moves the FSM.
    always_comb begin
        w_state_nxt = r_state;
        if (r_adv) begin
            case (r_state)
                ST_SEED:   if (w_seed_done && (w_seed_lfsr != '0)) w_state_nxt = ST_VERIFY;
                ST_VERIFY: begin
`ifdef PRBS_CHK_POLARITY_EN
                    if (w_match) begin
                        if (r_mis_cnt != '0) w_state_nxt = ST_SEED;
                        else if (w_lock)     w_state_nxt = ST_LOCKED;
                    end else if ((r_match_cnt != '0) || w_inv_done) begin
                        w_state_nxt = ST_SEED;
                    end
`else
                    if (!w_match)    w_state_nxt = ST_SEED;
                    else if (w_lock) w_state_nxt = ST_LOCKED;
`endif
                end
                ST_LOCKED: if (w_unlock) w_state_nxt = ST_SEED;
                default:   w_state_nxt = ST_SEED;
            endcase
        end
    end

    // Output decode: which counters step on this cycle.
    always_comb begin
        w_cnt_bit = r_adv && (r_state == ST_LOCKED);
        w_cnt_err = w_cnt_bit && !w_match;
`ifdef PRBS_CHK_POLARITY_EN
        w_pol_flip = r_adv && (r_state == ST_VERIFY) && w_inv_done;
`endif
    end

    // LFSR, seed/verify/window counters advance once per consumed bit.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_adv       <= 1'b0;
            r_lfsr      <= '0;
            r_shift_cnt <= '0;
            r_match_cnt <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
        end else begin
            r_adv <= i_cke_rx;
            if (r_adv) begin
                case (r_state)
                    ST_SEED: begin
                        r_lfsr      <= w_seed_lfsr;
                        if (!w_seed_done) r_shift_cnt <= r_shift_cnt + SW'(1);
                        r_match_cnt <= '0;
                        r_win_cnt   <= '0;
                        r_win_err   <= '0;
                    end
                    ST_VERIFY: begin
                        r_lfsr      <= w_seed_lfsr;
                        r_shift_cnt <= '0;
                        if (w_state_nxt != ST_VERIFY) r_match_cnt <= '0;
                        else if (w_match)             r_match_cnt <= r_match_cnt + MW'(1);
                    end
                    ST_LOCKED: begin
                        r_lfsr      <= w_fly_lfsr;
                        r_shift_cnt <= '0;
                        r_match_cnt <= '0;
                        if (w_unlock || w_win_last) begin
                            r_win_cnt <= '0;
                            r_win_err <= '0;
                        end else begin
                            r_win_cnt <= r_win_cnt + WW'(1);
                            if (!w_match) r_win_err <= r_win_err + EW'(1);
                        end
                    end
                    default: r_lfsr <= '0;
                endcase
            end
        end
    end

    // Saturating BER counters and error pulse; a coincident clear beats an increment.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_bit_count <= '0;
            r_err_count <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_err_pulse <= w_cnt_err;
            if (i_clr_cnt) begin
                r_bit_count <= '0;
                r_err_count <= '0;
            end else begin
                if (w_cnt_bit && (r_bit_count != '1)) r_bit_count <= r_bit_count + CNT_WIDTH'(1);
                if (w_cnt_err && (r_err_count != '1)) r_err_count <= r_err_count + CNT_WIDTH'(1);
            end
        end
    end

`ifdef PRBS_CHK_POLARITY_EN
    // Mismatch run length in VERIFY and sticky polarity toggle.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_mis_cnt <= '0;
            r_pol     <= 1'b0;
        end else if (r_adv) begin
            if ((r_state != ST_VERIFY) || (w_state_nxt != ST_VERIFY)) r_mis_cnt <= '0;
            else if (!w_match)                                        r_mis_cnt <= r_mis_cnt + MW'(1);
            if (w_pol_flip) r_pol <= ~r_pol;
        end
    end
`endif

    assign o_locked    = (r_state == ST_LOCKED);
    assign o_err_pulse = r_err_pulse;
    assign o_bit_count = r_bit_count;
    assign o_err_count = r_err_count;
    assign o_polarity  = w_pol;

endmodule
